// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard, flush and freeze control with SRAM wait tracking.
// Combinational freeze/flush decode plus saturating perf counters.
module hazard_flush_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        forward_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        sram_ready,
  input  logic        cnt_clr,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        freeze_id_ex,
  output logic        freeze_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TIMEOUT
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       to_set;
  logic       mem_stall;
  logic       raw_exe, raw_mem, data_haz;

  assign mem_stall = mem_req & ~sram_ready;

  assign raw_exe = exe_wb_en &
    ((exe_dest == src1) | (two_src & (exe_dest == src2)));
  assign raw_mem = mem_wb_en &
    ((mem_dest == src1) | (two_src & (mem_dest == src2)));

  // With forwarding only a load-use needs a bubble.
  assign data_haz = forward_en ? (raw_exe & exe_mem_read)
                               : (raw_exe | raw_mem);

  // Prioritised freeze/flush decode: mem stall, branch, data hazard.
  always_comb begin
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    freeze_id_ex  = 1'b0;
    freeze_ex_mem = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    if (mem_stall) begin
      freeze_pc     = 1'b1;
      freeze_if_id  = 1'b1;
      freeze_id_ex  = 1'b1;
      freeze_ex_mem = 1'b1;
    end else if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (data_haz) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  // Next-state and wait counter for SRAM wait tracking.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    to_set    = 1'b0;
    unique case (state)
      RUN: begin
        wait_nxt = 8'd0;
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (sram_ready | ~mem_req) begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == TO_CNT) begin
          state_nxt = TIMEOUT;
          to_set    = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      TIMEOUT: begin
        if (~mem_stall) begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = 8'd0;
      end
    endcase
  end

  // State register; cnt_clr does not touch the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Saturating perf counters and sticky timeout; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
      mem_timeout  <= 1'b0;
    end else if (cnt_clr) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
      mem_timeout  <= 1'b0;
    end else begin
      if (freeze_pc && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (flush_if_id && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
      if (to_set)
        mem_timeout <= 1'b1;
    end
  end

endmodule
